// File: rtl/video_pkg.sv
// video_pkg: shared pixel/stream types, packer phases and screen constants
package video_pkg;
  typedef logic [23:0] rgb_t;
  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [31:0] tdata;
  } axis_word_t;
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
  localparam int SCREEN_WIDTH    = 640;
  localparam int SCREEN_HEIGHT   = 480;
  localparam int PIX_PER_GROUP   = 4;
  localparam int WORDS_PER_GROUP = 3;
endpackage

// File: rtl/axis_word_fifo.sv
// axis_word_fifo: dual-push (0-2 per cycle), single-pop word FIFO with free-slot count
// Ports: clk/reset; push_a/word_a, push_b/word_b (b is written after a);
//        pop; head (zero when empty); empty; free = slots left after this cycle.
module axis_word_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_a,
  input  axis_word_t               word_a,
  input  logic                     push_b,
  input  axis_word_t               word_b,
  input  logic                     pop,
  output axis_word_t               head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  axis_word_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic ok_a, ok_b, pop_ok, overflow;
  // Fullness is judged before this cycle's pop, so a full FIFO never overwrites its head.
  always_comb begin
    pop_ok  = pop && !empty;
    ok_a    = push_a && count != CW'(DEPTH);
    ok_b    = push_b && count + CW'(ok_a) != CW'(DEPTH);
    count_n = count + CW'(ok_a) + CW'(ok_b) - CW'(pop_ok);
  end
  assign empty = count == '0;
  assign head  = empty ? '0 : mem[rd_ptr];
  assign free  = CW'(DEPTH) - count_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(ok_a) + AW'(ok_b);
      rd_ptr   <= rd_ptr + AW'(pop_ok);
      count    <= count_n;
      overflow <= overflow | (push_a & !ok_a) | (push_b & !ok_b);
    end
  end
  always_ff @(posedge clk) begin
    if (ok_a) mem[wr_ptr] <= word_a;
    if (ok_b) mem[wr_ptr + AW'(ok_a)] <= word_b;
  end
endmodule

// File: rtl/video_axis_packer.sv
// video_axis_packer: packs 24-bit pixels 4:3 into 32-bit AXI4-Stream video words
// Ports: clk/reset; pixel in valid_i, colour_i, first_i, last_x_i; ready_o to upstream;
//        AXI master m_tdata, m_tvalid, m_tready, m_tuser (start of frame), m_tlast (end of line).
module video_axis_packer
  import video_pkg::*;
#(
  parameter int RBG_SIZE   = 24,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [RBG_SIZE-1:0]   colour_i,
  input  logic                  first_i,
  input  logic                  last_x_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  phase_t phase, phase_n, eff;
  rgb_t c, residue, residue_n, res_n;
  logic [31:0] w_norm;
  logic sof_pending, sof_n, sof, has_n, flush, push_a, push_b, pop, empty;
  axis_word_t word_a, word_b, head;
  logic [FW-1:0] free;
  assign c = colour_i;
  // A start-of-frame pixel abandons any partial group and restarts at phase 0.
  // The flush word is always the zero-extended residue left after this pixel.
  always_comb begin
    eff          = first_i ? PH0 : phase;
    w_norm       = eff == PH1 ? {c[7:0], residue} :
                   eff == PH2 ? {c[15:0], residue[15:0]} : {c, residue[7:0]};
    res_n        = eff == PH0 ? c : eff == PH1 ? {8'h0, c[23:8]} :
                   eff == PH2 ? {16'h0, c[23:16]} : 24'h0;
    has_n        = valid_i && eff != PH0;
    flush        = valid_i && last_x_i && eff != PH3;
    sof          = sof_pending || (valid_i && first_i);
    push_a       = has_n || flush;
    push_b       = has_n && flush;
    word_a.tuser = sof;
    word_a.tlast = last_x_i && !push_b;
    word_a.tdata = has_n ? w_norm : {8'h0, res_n};
    word_b.tuser = 1'b0;
    word_b.tlast = 1'b1;
    word_b.tdata = {8'h0, res_n};
    phase_n      = !valid_i ? phase : last_x_i ? PH0 : phase_t'(eff + 2'd1);
    residue_n    = !valid_i ? residue : last_x_i ? 24'h0 : res_n;
    sof_n        = sof && !push_a;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PH0;
      residue     <= '0;
      sof_pending <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      phase       <= phase_n;
      residue     <= residue_n;
      sof_pending <= sof_n;
      ready_o     <= free >= FW'(4);
    end
  end
  axis_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_a (push_a),
    .word_a (word_a),
    .push_b (push_b),
    .word_b (word_b),
    .pop    (pop),
    .head   (head),
    .empty  (empty),
    .free   (free)
  );
  assign m_tvalid = !empty;
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = head.tdata;
  assign m_tuser  = head.tuser;
  assign m_tlast  = head.tlast;
endmodule

// File: tb/tb_video_axis_packer.sv
// tb_video_axis_packer: scoreboard bench for video_axis_packer using a byte-stream model
module tb_video_axis_packer;
  logic clk = 1'b0, reset = 1'b1, valid_i = 1'b0, first_i = 1'b0, last_x_i = 1'b0, m_tready = 1'b1;
  logic [23:0] colour_i = '0;
  logic ready_o, m_tvalid, m_tuser, m_tlast;
  logic [31:0] m_tdata;
  int checks = 0, errors = 0;
  logic [33:0] q[$];
  logic [33:0] got_w[$];
  logic [7:0] bytes[$];
  bit sof, en, post_rst, exp_rdy, rdy_q;
  int n_new, popped, tlasts, drops, mode;

  video_axis_packer dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .colour_i (colour_i),
    .first_i  (first_i),
    .last_x_i (last_x_i),
    .ready_o  (ready_o),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic emit(logic [31:0] d);
    q.push_back({sof, 1'b0, d});
    sof = 1'b0;
    n_new++;
  endtask

  // Pixels are a little-endian byte stream cut into 32-bit words; a line end pads the tail.
  task automatic model_pixel(logic [23:0] c, logic f, logic l);
    logic [31:0] d;
    if (f) begin
      bytes.delete();
      sof = 1'b1;
    end
    for (int i = 0; i < 3; i++) bytes.push_back(c[8*i +: 8]);
    while (bytes.size() >= 4) begin
      emit({bytes[3], bytes[2], bytes[1], bytes[0]});
      repeat (4) void'(bytes.pop_front());
    end
    if (l) begin
      if (bytes.size() > 0) begin
        d = '0;
        for (int i = 0; i < bytes.size(); i++) d[8*i +: 8] = bytes[i];
        emit(d);
        bytes.delete();
      end
      q[q.size()-1][32] = 1'b1;
    end
  endtask

  task automatic cycle();
    bit ev;
    @(negedge clk);
    if (en) begin
      ev = (q.size() - n_new) > 0;
      check("m_tvalid", m_tvalid, ev);
      if (post_rst) begin
        check("rst_tdata", m_tdata, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_tlast", m_tlast, 0);
        post_rst = 1'b0;
      end
      if (m_tvalid && ev) begin
        check("head_word", {m_tuser, m_tlast, m_tdata}, q[0]);
        if (m_tready) begin
          if (q[0][32]) tlasts++;
          got_w.push_back(q[0]);
          void'(q.pop_front());
          popped++;
        end
      end
      check("ready_o", ready_o, exp_rdy);
      check("fifo_within_depth", dut.u_fifo.count <= 8, 1);
      if (!ready_o) drops++;
    end
    exp_rdy = !reset && (8 - q.size()) >= 4;
    n_new = 0;
    rdy_q = ready_o;
    @(posedge clk);
    #1;
    m_tready = mode == 1 ? !m_tready : mode == 0;
  endtask

  task automatic drive(logic [23:0] c, logic f, logic l);
    valid_i = 1'b1;
    colour_i = c;
    first_i = f;
    last_x_i = l;
    model_pixel(c, f, l);
    cycle();
    valid_i = 1'b0;
    first_i = 1'b0;
    last_x_i = 1'b0;
  endtask

  task automatic send(logic [23:0] c, logic f, logic l);
    int g = 0;
    while (!rdy_q && g < 100) begin
      g++;
      cycle();
    end
    if (!rdy_q) check("ready_timeout", rdy_q, 1);
    drive(c, f, l);
  endtask

  task automatic drain();
    int g = 0;
    mode = 0;
    while (q.size() > 0 && g < 400) begin
      g++;
      cycle();
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    bytes.delete();
    q.delete();
    sof = 1'b0;
    reset = 1'b0;
    post_rst = 1'b1;
  endtask

  initial begin
    mode = 0;
    en = 1'b0;
    cycle();
    en = 1'b1;
    do_reset();
    cycle();
    got_w.delete();
    send(24'hAABBCC, 1, 0);
    send(24'h112233, 0, 0);
    send(24'h445566, 0, 0);
    send(24'h778899, 0, 1);
    drain();
    check("t1_w0", got_w[0], 34'h2_33AABBCC);
    check("t1_w1", got_w[1], 34'h0_55661122);
    check("t1_w2", got_w[2], 34'h1_77889944);
    got_w.delete();
    for (int i = 1; i <= 5; i++) send(24'(i), 0, i == 5);
    drain();
    check("t2_count", got_w.size(), 4);
    check("t2_w3", got_w[3], 34'h1_00000005);
    check("t2_phase", dut.phase, 0);
    got_w.delete();
    mode = 2;
    send(24'h112233, 0, 0);
    send(24'h445566, 0, 1);
    check("t3_two_pushes", dut.u_fifo.count, 2);
    drain();
    check("t3_w0", got_w[0], 34'h0_66112233);
    check("t3_w1", got_w[1], 34'h1_00004455);
    got_w.delete();
    popped = 0;
    tlasts = 0;
    drops = 0;
    mode = 1;
    for (int i = 0; i < 640; i++) send(24'($urandom), i == 0, i == 639);
    drain();
    check("t4_words", popped, 480);
    check("t4_tlasts", tlasts, 1);
    check("t4_last_flag", got_w[479][32], 1);
    check("t4_ready_dropped", drops > 0, 1);
    mode = 2;
    begin
      bit f = 1'b1;
      for (int k = 0; k < 20; k++)
        if (rdy_q) begin
          drive(24'($urandom), f, 0);
          f = 1'b0;
        end else cycle();
    end
    mode = 0;
    send(24'($urandom), 0, 1);
    drain();
    got_w.delete();
    mode = 2;
    send(24'hA1A2A3, 0, 0);
    send(24'hB1B2B3, 0, 1);
    send(24'hC1C2C3, 1, 0);
    send(24'hD1D2D3, 0, 0);
    check("t6_queued", dut.u_fifo.count, 3);
    do_reset();
    cycle();
    got_w.delete();
    mode = 0;
    send(24'h010203, 1, 0);
    send(24'h040506, 0, 1);
    drain();
    check("t6_count", got_w.size(), 2);
    check("t6_w0", got_w[0], 34'h2_06010203);
    check("t6_w1", got_w[1], 34'h1_00000405);
    check("overflow", dut.u_fifo.overflow, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
